packed_field_arbiter: RTL and testbench

PACKED_FIELD_ARBITER -- requirements
Module: packed_field_arbiter

---
 rtl/packed_field_pkg.sv | 14 +
 rtl/rr_arb2.sv | 44 ++++
 rtl/packed_field_arbiter.sv | 118 +++++++++++
 tb/tb_packed_field_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/packed_field_pkg.sv
// Shared types for the packed-field arbiter: FSM state encoding and counter limits.
package packed_field_pkg;

  typedef enum logic [1:0] {
    StEmpty,
    StHave0,
    StHave1,
    StPublish
  } state_e;

  localparam int unsigned CntWidth = 8;
  localparam logic [CntWidth-1:0] CntMax = '1;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; prio names the requester that wins a tie.
module rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_enable,
  output logic o_gnt0,
  output logic o_gnt1,
  output logic o_prio
);

  logic r_prio;
  logic w_gnt0;
  logic w_gnt1;

  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (i_enable) begin
      if (i_req0 && (!i_req1 || !r_prio)) begin
        w_gnt0 = 1'b1;
      end else if (i_req1) begin
        w_gnt1 = 1'b1;
      end
    end
  end

  // A grant is only issued with its request present, so a grant is an accepted write.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prio <= 1'b0;
    end else if (w_gnt0) begin
      r_prio <= 1'b1;
    end else if (w_gnt1) begin
      r_prio <= 1'b0;
    end
  end

  assign o_gnt0 = w_gnt0;
  assign o_gnt1 = w_gnt1;
  assign o_prio = r_prio;

endmodule

// File: rtl/packed_field_arbiter.sv
// Two requesters fill the halves of a packed shadow struct; once both halves are written
// the struct is published to snap_out with a one-cycle pub_valid pulse.
module packed_field_arbiter
  import packed_field_pkg::*;
#(
  parameter int unsigned FIELD0_WIDTH = 4,
  parameter int unsigned FIELD1_WIDTH = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 req0_valid,
  input  logic [FIELD0_WIDTH-1:0]              req0_data,
  output logic                                 req0_ready,
  input  logic                                 req1_valid,
  input  logic [FIELD1_WIDTH-1:0]              req1_data,
  output logic                                 req1_ready,
  output logic [FIELD0_WIDTH+FIELD1_WIDTH-1:0] snap_out,
  output logic                                 pub_valid,
  output logic [CntWidth-1:0]                  overwrite_cnt
);

  typedef struct packed {
    logic [FIELD0_WIDTH-1:0] field0;
    logic [FIELD1_WIDTH-1:0] field1;
  } snap_t;

  state_e              r_state;
  snap_t               r_shadow;
  snap_t               r_snap;
  snap_t               w_shadow_next;
  logic                r_pub_valid;
  logic [CntWidth-1:0] r_ovw_cnt;
  logic                w_enable;
  logic                w_gnt0;
  logic                w_gnt1;
  logic                w_prio;
  logic                w_acc0;
  logic                w_acc1;

  assign w_enable = (r_state != StPublish) && !rst;

  rr_arb2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .i_req0   (req0_valid),
    .i_req1   (req1_valid),
    .i_enable (w_enable),
    .o_gnt0   (w_gnt0),
    .o_gnt1   (w_gnt1),
    .o_prio   (w_prio)
  );

  assign w_acc0 = req0_valid && w_gnt0;
  assign w_acc1 = req1_valid && w_gnt1;

  // Arbiter grants at most one requester, so this is the single write path.
  always_comb begin
    w_shadow_next = r_shadow;
    if (w_acc0) begin
      w_shadow_next.field0 = req0_data;
    end
    if (w_acc1) begin
      w_shadow_next.field1 = req1_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StEmpty;
      r_shadow    <= '0;
      r_snap      <= '0;
      r_pub_valid <= 1'b0;
      r_ovw_cnt   <= '0;
    end else begin
      r_shadow    <= w_shadow_next;
      r_pub_valid <= 1'b0;
      case (r_state)
        StEmpty: begin
          if (w_acc0) begin
            r_state <= StHave0;
          end else if (w_acc1) begin
            r_state <= StHave1;
          end
        end
        StHave0: begin
          if (w_acc1) begin
            r_state     <= StPublish;
            r_snap      <= w_shadow_next;
            r_pub_valid <= 1'b1;
          end else if (w_acc0 && (r_ovw_cnt != CntMax)) begin
            r_ovw_cnt <= r_ovw_cnt + 1'b1;
          end
        end
        StHave1: begin
          if (w_acc0) begin
            r_state     <= StPublish;
            r_snap      <= w_shadow_next;
            r_pub_valid <= 1'b1;
          end else if (w_acc1 && (r_ovw_cnt != CntMax)) begin
            r_ovw_cnt <= r_ovw_cnt + 1'b1;
          end
        end
        StPublish: r_state <= StEmpty;
        default:   r_state <= StEmpty;
      endcase
    end
  end

  assign req0_ready    = w_gnt0;
  assign req1_ready    = w_gnt1;
  assign snap_out      = r_snap;
  assign pub_valid     = r_pub_valid;
  assign overwrite_cnt = r_ovw_cnt;

  logic w_unused;
  assign w_unused = w_prio;

endmodule

// File: tb/tb_packed_field_arbiter.sv
// Bench for packed_field_arbiter: directed scenarios plus randomized traffic against a model.
module tb_packed_field_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       v0, v1;
  logic [3:0] d0, d1;
  logic       rdy0, rdy1;
  logic [7:0] snap;
  logic       pub;
  logic [7:0] cnt;

  logic       b_v0, b_v1;
  logic [2:0] b_d0;
  logic [4:0] b_d1;
  logic       b_rdy0, b_rdy1;
  logic [7:0] b_snap;
  logic       b_pub;
  logic [7:0] b_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  packed_field_arbiter #(.FIELD0_WIDTH(4), .FIELD1_WIDTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .req0_valid    (v0),
    .req0_data     (d0),
    .req0_ready    (rdy0),
    .req1_valid    (v1),
    .req1_data     (d1),
    .req1_ready    (rdy1),
    .snap_out      (snap),
    .pub_valid     (pub),
    .overwrite_cnt (cnt)
  );

  packed_field_arbiter #(.FIELD0_WIDTH(3), .FIELD1_WIDTH(5)) dut_b (
    .clk           (clk),
    .rst           (rst),
    .req0_valid    (b_v0),
    .req0_data     (b_d0),
    .req0_ready    (b_rdy0),
    .req1_valid    (b_v1),
    .req1_data     (b_d1),
    .req1_ready    (b_rdy1),
    .snap_out      (b_snap),
    .pub_valid     (b_pub),
    .overwrite_cnt (b_cnt)
  );

  // Reference model: which fields have arrived since the last publish, and the tie-break.
  bit m_got0, m_got1, m_pub, m_prio, m_r0, m_r1;
  int m_sh0, m_sh1, m_snap, m_cnt;

  task automatic model_reset();
    m_got0 = 0; m_got1 = 0; m_pub = 0; m_prio = 0;
    m_sh0 = 0; m_sh1 = 0; m_snap = 0; m_cnt = 0;
  endtask

  task automatic model_grants();
    bit open;
    open = !rst && !m_pub;
    m_r0 = open && v0 && (!v1 || m_prio == 0);
    m_r1 = open && v1 && (!v0 || m_prio == 1);
  endtask

  task automatic model_edge();
    if (rst) begin
      model_reset();
    end else if (m_pub) begin
      m_pub = 0;
    end else begin
      if (m_r0) begin
        if (m_got0) m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
        m_sh0 = int'(d0); m_got0 = 1; m_prio = 1;
      end else if (m_r1) begin
        if (m_got1) m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
        m_sh1 = int'(d1); m_got1 = 1; m_prio = 0;
      end
      if (m_got0 && m_got1) begin
        m_snap = m_sh0 * 16 + m_sh1;
        m_pub = 1; m_got0 = 0; m_got1 = 0;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; v0 = 1'b0; v1 = 1'b0; b_v0 = 1'b0; b_v1 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; v0 = 1'b1; v1 = 1'b1; d0 = 4'h6; d1 = 4'h9;
    b_v0 = 1'b0; b_v1 = 1'b0; b_d0 = '0; b_d1 = '0;
    @(negedge clk); #1;
    checks++;
    if (rdy0 !== 1'b0 || rdy1 !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got %b%b expected 00", rdy0, rdy1);
    end
    checks++;
    if (snap !== 8'h00 || pub !== 1'b0 || cnt !== 8'h00) begin
      errors++; $display("FAIL reset_outputs: got snap=%h pub=%b cnt=%0d expected 00/0/0",
                         snap, pub, cnt);
    end
    rst = 1'b0; v1 = 1'b0; #1;
    checks++;
    if (rdy0 !== 1'b1) begin
      errors++; $display("FAIL first_cycle_accept: got %b expected 1", rdy0);
    end
    v0 = 1'b0;
  endtask

  task automatic test_basic();
    do_reset();
    v0 = 1'b1; d0 = 4'hA; #1;
    checks++;
    if (rdy0 !== 1'b1) begin
      errors++; $display("FAIL basic_rdy0: got %b expected 1", rdy0);
    end
    @(negedge clk);
    checks++;
    if (pub !== 1'b0) begin
      errors++; $display("FAIL basic_early_pub: got %b expected 0", pub);
    end
    v0 = 1'b0; v1 = 1'b1; d1 = 4'h5; #1;
    checks++;
    if (rdy1 !== 1'b1) begin
      errors++; $display("FAIL basic_rdy1: got %b expected 1", rdy1);
    end
    @(negedge clk);
    v1 = 1'b0;
    checks++;
    if (pub !== 1'b1 || snap !== 8'hA5 || snap[7:4] !== 4'hA || snap[3:0] !== 4'h5) begin
      errors++; $display("FAIL basic_publish: got pub=%b snap=%h expected 1/a5", pub, snap);
    end
    @(negedge clk);
    checks++;
    if (pub !== 1'b0 || snap !== 8'hA5) begin
      errors++; $display("FAIL basic_after: got pub=%b snap=%h expected 0/a5", pub, snap);
    end
  endtask

  task automatic test_both_held();
    @(negedge clk);
    rst = 1'b1; v0 = 1'b1; v1 = 1'b1; d0 = 4'h3; d1 = 4'hC;
    @(negedge clk);
    rst = 1'b0; #1;
    checks++;
    if (rdy0 !== 1'b1 || rdy1 !== 1'b0) begin
      errors++; $display("FAIL held_first: got %b%b expected 10", rdy0, rdy1);
    end
    @(negedge clk); #1;
    checks++;
    if (rdy0 !== 1'b0 || rdy1 !== 1'b1) begin
      errors++; $display("FAIL held_second: got %b%b expected 01", rdy0, rdy1);
    end
    @(negedge clk); #1;
    checks++;
    if (pub !== 1'b1 || snap !== 8'h3C || rdy0 !== 1'b0 || rdy1 !== 1'b0) begin
      errors++; $display("FAIL held_publish: got pub=%b snap=%h rdy=%b%b expected 1/3c/00",
                         pub, snap, rdy0, rdy1);
    end
    @(negedge clk); #1;
    checks++;
    if (pub !== 1'b0 || rdy0 !== 1'b1 || rdy1 !== 1'b0) begin
      errors++; $display("FAIL held_regrant0: got pub=%b rdy=%b%b expected 0/10", pub, rdy0, rdy1);
    end
    @(negedge clk); #1;
    checks++;
    if (rdy1 !== 1'b1 || rdy0 !== 1'b0) begin
      errors++; $display("FAIL held_regrant1: got %b%b expected 01", rdy0, rdy1);
    end
    @(negedge clk);
    checks++;
    if (pub !== 1'b1 || snap !== 8'h3C) begin
      errors++; $display("FAIL held_republish: got pub=%b snap=%h expected 1/3c", pub, snap);
    end
    v0 = 1'b0; v1 = 1'b0;
  endtask

  task automatic test_overwrite();
    logic [3:0] vals [3];
    vals[0] = 4'h1; vals[1] = 4'h2; vals[2] = 4'h7;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      v0 = 1'b1; d0 = vals[i];
      @(negedge clk);
    end
    v0 = 1'b0; v1 = 1'b1; d1 = 4'h9;
    @(negedge clk);
    v1 = 1'b0;
    checks++;
    if (cnt !== 8'd2 || snap !== 8'h79 || pub !== 1'b1) begin
      errors++; $display("FAIL overwrite: got cnt=%0d snap=%h pub=%b expected 2/79/1",
                         cnt, snap, pub);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    v0 = 1'b1;
    for (int i = 1; i <= 301; i++) begin
      d0 = 4'($urandom_range(15));
      @(negedge clk);
      if (i == 11) begin
        checks++;
        if (cnt !== 8'd10) begin
          errors++; $display("FAIL sat_mid: got %0d expected 10", cnt);
        end
      end
      if (i == 256) begin
        checks++;
        if (cnt !== 8'd255) begin
          errors++; $display("FAIL sat_reach: got %0d expected 255", cnt);
        end
      end
    end
    v0 = 1'b0;
    checks++;
    if (cnt !== 8'd255 || pub !== 1'b0) begin
      errors++; $display("FAIL sat_hold: got cnt=%0d pub=%b expected 255/0", cnt, pub);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    v0 = 1'b1; d0 = 4'hF;
    @(negedge clk);
    v0 = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; v1 = 1'b1; d1 = 4'h4; #1;
    checks++;
    if (rdy1 !== 1'b1) begin
      errors++; $display("FAIL midrst_rdy1: got %b expected 1", rdy1);
    end
    @(negedge clk);
    v1 = 1'b0;
    checks++;
    if (pub !== 1'b0 || snap !== 8'h00) begin
      errors++; $display("FAIL midrst_nopub: got pub=%b snap=%h expected 0/00", pub, snap);
    end
    @(negedge clk);
    checks++;
    if (pub !== 1'b0 || snap !== 8'h00) begin
      errors++; $display("FAIL midrst_still: got pub=%b snap=%h expected 0/00", pub, snap);
    end
    v0 = 1'b1; d0 = 4'h2;
    @(negedge clk);
    v0 = 1'b0;
    checks++;
    if (pub !== 1'b1 || snap !== 8'h24 || cnt !== 8'd0) begin
      errors++; $display("FAIL midrst_have1: got pub=%b snap=%h cnt=%0d expected 1/24/0",
                         pub, snap, cnt);
    end
  endtask

  task automatic test_unequal_widths();
    do_reset();
    b_v0 = 1'b1; b_d0 = 3'h5;
    @(negedge clk);
    b_v0 = 1'b0; b_v1 = 1'b1; b_d1 = 5'h11;
    @(negedge clk);
    b_v1 = 1'b0;
    checks++;
    if (b_pub !== 1'b1 || b_snap !== 8'hB1) begin
      errors++; $display("FAIL unequal: got pub=%b snap=%h expected 1/b1", b_pub, b_snap);
    end
  endtask

  task automatic test_random();
    do_reset();
    model_reset();
    for (int c = 0; c < 500; c++) begin
      rst = ($urandom_range(39) == 0);
      v0  = ($urandom_range(9) < 6);
      v1  = ($urandom_range(9) < 6);
      d0  = 4'($urandom_range(15));
      d1  = 4'($urandom_range(15));
      #1;
      model_grants();
      checks++;
      if (rdy0 !== m_r0 || rdy1 !== m_r1) begin
        errors++; $display("FAIL rand_ready c=%0d: got %b%b expected %b%b",
                           c, rdy0, rdy1, m_r0, m_r1);
      end
      model_edge();
      @(negedge clk);
      checks++;
      if (snap !== 8'(m_snap) || pub !== m_pub || cnt !== 8'(m_cnt)) begin
        errors++; $display("FAIL rand_out c=%0d: got snap=%h pub=%b cnt=%0d expected %h/%b/%0d",
                           c, snap, pub, cnt, 8'(m_snap), m_pub, m_cnt);
      end
    end
    rst = 1'b0; v0 = 1'b0; v1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_both_held();
    test_overwrite();
    test_saturate();
    test_reset_mid();
    test_unequal_widths();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
